// File: rtl/row_pixel_fetcher.sv
// Row pixel fetcher: reads COLS pixels of one frame row from a sync-read memory
// and streams them out through a small FIFO. Optional macro ROW_FETCH_TEST_PATTERN_EN.
module row_pixel_fetcher #(
    parameter int ROWS       = 720,
    parameter int COLS       = 1280,
    parameter int PIX_W      = 24,
    parameter int MEM_AW     = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        row_addr,
    input  logic              row_req,
`ifdef ROW_FETCH_TEST_PATTERN_EN
    input  logic              test_pat,
`endif
    output logic              row_busy,
    output logic              row_err,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_sof,
    output logic              pix_sol,
    output logic              pix_eol
);
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int EW  = PIX_W + 3;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    logic [1:0]        r_state;
    logic [9:0]        r_row;
    logic [MEM_AW-1:0] r_base;
    logic [CW-1:0]     r_col;
    logic [CW-1:0]     r_if_col;
    logic              r_inflight;
    logic              r_busy;
    logic              r_err;
    logic [EW-1:0]     r_fifo [FIFO_DEPTH];
    logic [FAW-1:0]    r_wp;
    logic [FAW-1:0]    r_rp;
    logic [FAW:0]      r_cnt;

    logic              w_accept;
    logic              w_reject;
    logic [FAW+1:0]    w_occ;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_pat;
    logic              w_sol;
    logic              w_eol;
    logic              w_sof;
    logic [PIX_W-1:0]  w_pdata;
    logic [EW-1:0]     w_entry;
    logic [EW-1:0]     w_head;

    assign w_accept = (r_state == S_IDLE) && row_req && (32'(row_addr) < ROWS);
    assign w_reject = (r_state == S_IDLE) && row_req && (32'(row_addr) >= ROWS);

    // FIFO slots already claimed, counting the read whose data lands this cycle
    assign w_occ   = {1'b0, r_cnt} + (FAW+2)'(r_inflight);
    assign w_issue = (r_state == S_FETCH) && (w_occ < (FAW+2)'(FIFO_DEPTH));

    assign mem_rd_en = w_issue && !w_pat;
    assign mem_addr  = r_base + MEM_AW'(r_col);

    assign w_push = r_inflight;
    assign w_pop  = pix_valid && pix_ready;

    assign w_sol = (r_if_col == '0);
    assign w_eol = (r_if_col == LAST_COL);
    assign w_sof = w_sol && (r_row == '0);

`ifdef ROW_FETCH_TEST_PATTERN_EN
    logic       r_pat;
    logic [7:0] w_c8;
    logic [23:0] w_gen;
    assign w_c8    = 8'(r_if_col);
    assign w_gen   = {r_row[7:0], w_c8, r_row[7:0] ^ w_c8};
    assign w_pat   = r_pat;
    assign w_pdata = r_pat ? PIX_W'(w_gen) : mem_rdata;
`else
    assign w_pat   = 1'b0;
    assign w_pdata = mem_rdata;
`endif

    assign w_entry = {w_sof, w_sol, w_eol, w_pdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_base     <= '0;
            r_col      <= '0;
            r_if_col   <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
`ifdef ROW_FETCH_TEST_PATTERN_EN
            r_pat      <= 1'b0;
`endif
        end else begin
            r_err      <= w_reject;
            r_inflight <= w_issue;
            if (w_issue) r_if_col <= r_col;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_row   <= row_addr;
                    r_base  <= MEM_AW'(row_addr) * MEM_AW'(COLS);
                    r_col   <= '0;
                    r_busy  <= 1'b1;
`ifdef ROW_FETCH_TEST_PATTERN_EN
                    r_pat   <= test_pat;
`endif
                    r_state <= S_FETCH;
                end
                S_FETCH: if (w_issue) begin
                    if (r_col == LAST_COL) begin
                        r_col   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_col   <= r_col + 1'b1;
                    end
                end
                S_DRAIN: if (r_cnt == '0 && !r_inflight) begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wp] <= w_entry;
    end

    assign w_head    = r_fifo[r_rp];
    assign pix_valid = (r_cnt != '0);
    assign pix_data  = pix_valid ? w_head[PIX_W-1:0] : '0;
    assign pix_eol   = pix_valid && w_head[PIX_W];
    assign pix_sol   = pix_valid && w_head[PIX_W+1];
    assign pix_sof   = pix_valid && w_head[PIX_W+2];
    assign row_busy  = r_busy;
    assign row_err   = r_err;
endmodule

// File: tb/tb_row_pixel_fetcher.sv
// Scoreboard bench for row_pixel_fetcher (COLS=8): expected pixels and read
// addresses are queued at request time and checked by a decoupled monitor.
module tb_row_pixel_fetcher;
    localparam int ROWS = 720, COLS = 8, PIX_W = 24, MEM_AW = 20, DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [9:0]        row_addr = '0;
    logic              row_req = 1'b0;
`ifdef ROW_FETCH_TEST_PATTERN_EN
    logic              test_pat = 1'b0;
`endif
    logic              row_busy, row_err, mem_rd_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rdata = '0;
    logic              pix_valid;
    logic              pix_ready = 1'b1;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_sof, pix_sol, pix_eol;

    row_pixel_fetcher #(.ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W), .MEM_AW(MEM_AW),
                        .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .row_addr(row_addr), .row_req(row_req),
`ifdef ROW_FETCH_TEST_PATTERN_EN
        .test_pat(test_pat),
`endif
        .row_busy(row_busy), .row_err(row_err), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
        .pix_sol(pix_sol), .pix_eol(pix_eol));

    always #5 clk = ~clk;

    function automatic logic [PIX_W-1:0] memf(input logic [MEM_AW-1:0] a);
        logic [31:0] t;
        t = ({12'b0, a} * 32'h9E3779B1) ^ 32'h00A5C3;
        return t[PIX_W-1:0];
    endfunction

    function automatic logic [PIX_W-1:0] patf(input int r, input int c);
        logic [7:0] r8, c8;
        r8 = r[7:0];
        c8 = c[7:0];
        return PIX_W'({r8, c8, r8 ^ c8});
    endfunction

    // Synchronous-read frame memory
    always @(posedge clk) if (mem_rd_en) mem_rdata <= memf(mem_addr);

    typedef struct packed {
        logic [PIX_W-1:0] d;
        logic sof, sol, eol;
    } exp_t;

    exp_t              sbq[$];
    logic [MEM_AW-1:0] addrq[$];
    int n_tests = 0, n_fail = 0;
    int n_iss = 0, n_pop = 0;
    bit rmode = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic        stall;
        logic [27:0] prev, cur;
        exp_t        e;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sbq.delete();
                addrq.delete();
                n_iss = 0;
                n_pop = 0;
                stall = 1'b0;
                continue;
            end
            if (mem_rd_en) begin
                chk("rd_occupancy_lt_depth", 64'((n_iss - n_pop) < DEPTH), 1);
                chk("rd_expected", 64'(addrq.size() > 0), 1);
                if (addrq.size() > 0) chk("rd_addr", 64'(mem_addr), 64'(addrq.pop_front()));
                n_iss++;
            end
            cur = {pix_valid, pix_data, pix_sof, pix_sol, pix_eol};
            if (stall) chk("stall_hold", 64'(cur), 64'(prev));
            if (pix_valid && pix_ready) begin
                chk("pix_expected", 64'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("pix_data_flags", 64'({pix_data, pix_sof, pix_sol, pix_eol}), 64'(e));
                end
                n_pop++;
            end
            stall = pix_valid && !pix_ready;
            prev  = cur;
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1 pix_ready = rmode ? 1'($urandom % 2) : 1'b1;
        end
    endtask

    task automatic chk_reset_outs(input string nm);
        chk(nm, 64'({row_busy, row_err, mem_rd_en, mem_addr, pix_valid, pix_sof,
                      pix_sol, pix_eol, pix_data}), 0);
    endtask

    task automatic do_req(input int addr, input bit pat, input bit lat);
        int k;
        exp_t e;
        k = 0;
        while (row_busy && k < 300) begin @(posedge clk); #1; k++; end
        chk("idle_before_req", 64'(row_busy), 0);
        @(posedge clk); #1;
        row_addr = 10'(addr);
        row_req  = 1'b1;
`ifdef ROW_FETCH_TEST_PATTERN_EN
        test_pat = pat;
`endif
        if (addr < ROWS) begin
            for (int c = 0; c < COLS; c++) begin
                e.d   = pat ? patf(addr, c) : memf(MEM_AW'(addr * COLS + c));
                e.sol = (c == 0);
                e.eol = (c == COLS - 1);
                e.sof = (c == 0) && (addr == 0);
                sbq.push_back(e);
                if (!pat) addrq.push_back(MEM_AW'(addr * COLS + c));
            end
        end
        @(posedge clk); #1;
        row_req  = 1'b0;
        row_addr = 10'($urandom);
        if (addr >= ROWS) begin
            chk("err_pulse_hi", 64'(row_err), 1);
            chk("err_no_busy", 64'(row_busy), 0);
            @(posedge clk); #1;
            chk("err_pulse_lo", 64'(row_err), 0);
            chk("err_no_busy2", 64'(row_busy), 0);
        end else if (lat) begin
            chk("lat_first_read", 64'(mem_rd_en), 1);
            chk("lat_busy", 64'(row_busy), 1);
            @(posedge clk); #1;
            chk("lat_valid_c2", 64'(pix_valid), 0);
            @(posedge clk); #1;
            chk("lat_valid_c3", 64'(pix_valid), 1);
            repeat (COLS - 1) @(posedge clk);
            #1 chk("throughput_left", 64'(sbq.size()), 1);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (sbq.size() > 0 && k < 400) begin @(posedge clk); #1; k++; end
        chk("row_drained", 64'(sbq.size()), 0);
        k = 0;
        while (row_busy && k < 10) begin @(posedge clk); #1; k++; end
        chk("busy_falls", 64'(k <= 3 && !row_busy), 1);
    endtask

    initial begin
        int a, p0;
        bit pat;
        fork
            monitor();
            ready_drv();
            begin
                #2000000;
                $display("FAIL watchdog: simulation did not finish");
                $fatal(1, "watchdog");
            end
        join_none
        #1 chk_reset_outs("reset_values");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // row 0 with latency/throughput checks, then row 5
        do_req(0, 1'b0, 1'b1);
        wait_done();
        do_req(5, 1'b0, 1'b0);
        @(posedge clk); #1;
        row_req = 1'b1; row_addr = 10'd720;
        @(posedge clk); #1;
        row_req = 1'b0;
        @(posedge clk); #1;
        chk("busy_req_no_err", 64'(row_err), 0);
        wait_done();

        do_req(720, 1'b0, 1'b0);
        do_req(1023, 1'b0, 1'b0);

        // reset while pixel 3 of row 4 is presented
        do_req(4, 1'b0, 1'b0);
        p0 = n_pop;
        a = 0;
        while (n_pop < p0 + 4 && a < 100) begin @(negedge clk); #1; a++; end
        chk("reached_pixel3", 64'(n_pop - p0), 4);
        reset = 1'b1;
        #1 chk_reset_outs("midrow_reset_values");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        do_req(1, 1'b0, 1'b0);
        wait_done();

`ifdef ROW_FETCH_TEST_PATTERN_EN
        do_req(2, 1'b1, 1'b0);
        wait_done();
`endif

        // randomized rows with random back-pressure
        rmode = 1'b1;
        for (int i = 0; i < 14; i++) begin
            a = ($urandom % 6 == 0) ? int'($urandom_range(720, 1023)) : int'($urandom_range(0, 719));
            if (i == 0) a = 0;
            pat = 1'b0;
`ifdef ROW_FETCH_TEST_PATTERN_EN
            pat = 1'($urandom % 3 == 0);
`endif
            do_req(a, pat, 1'b0);
            if (a < ROWS) wait_done();
        end
        rmode = 1'b0;
        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/row_pixel_fetcher.md
Name: row_pixel_fetcher

Overview:
- Downstream consumer of the 10-bit row address counter (0..720).
- On each accepted row request, latches the row address and computes the row base address in frame memory.
- Reads COLS pixels for that row over a synchronous-read memory port.
- Streams the pixels out on a valid/ready interface with start-of-frame, start-of-line and end-of-line markers; an internal FIFO absorbs memory latency and output back-pressure.

Parameters:
- ROWS, 720, number of valid rows; row_addr >= ROWS is rejected.
- COLS, 1280, pixels per row.
- PIX_W, 24, pixel width in bits.
- MEM_AW, 20, memory address width; must satisfy ROWS*COLS <= 2^MEM_AW.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- row_addr  in  10  row index from the address counter
- row_req  in  1  request to fetch row_addr; sampled only in IDLE
- row_busy  out  1  high from an accepted request until the last pixel has left
- row_err  out  1  one-cycle pulse when a request has row_addr >= ROWS
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  MEM_AW  memory read address
- mem_rdata  in  PIX_W  read data, valid exactly 1 cycle after mem_rd_en
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  downstream ready
- pix_data  out  PIX_W  pixel
- pix_sof  out  1  first pixel of row 0
- pix_sol  out  1  first pixel of any row
- pix_eol  out  1  last pixel (col COLS-1) of any row

Behaviour:
- Reset: async, active-high; clock clk. All state returns to IDLE.
- Reset values: row_busy=0, row_err=0, mem_rd_en=0, mem_addr=0, pix_valid=0, pix_sof=0, pix_sol=0, pix_eol=0, pix_data=0. FIFO empty, column counter=0, in-flight flag=0.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE, row_req=1, row_addr<ROWS:
  - Latch row_addr.
  - base = row_addr*COLS, computed at MEM_AW width (zero-extended multiply, no truncation within the legal range).
  - col=0, row_busy=1 next cycle, go to FETCH.
- IDLE, row_req=1, row_addr>=ROWS:
  - row_err=1 for one cycle.
  - Stay in IDLE, no memory access.
- FETCH:
  - Issue mem_rd_en=1 with mem_addr=base+col whenever (fifo_count + inflight) < FIFO_DEPTH; col increments on each issue.
  - After issuing col=COLS-1, go to DRAIN.
  - Best case is one read per cycle.
- Read return: the cycle after mem_rd_en, mem_rdata is written into the FIFO with tags:
  - sol = (col_of_read == 0)
  - eol = (col_of_read == COLS-1)
  - sof = sol && (row == 0)
- DRAIN: when the FIFO is empty and nothing is in flight, row_busy=0 and go to IDLE.
- Output side:
  - pix_valid = FIFO non-empty.
  - pix_data and flags come from the FIFO head.
  - Pop when pix_valid && pix_ready.
  - Output held stable while pix_valid && !pix_ready.
- Simultaneous push and pop in the same cycle is allowed; count is unchanged.
- FIFO overflow is impossible by the issue rule. Pop on empty is ignored.
- Latency: row_req accepted at cycle 0 -> first mem_rd_en at cycle 1 -> first pix_valid at cycle 3 (FIFO registered), assuming pix_ready=1.
- row_req while busy: ignored, with no error pulse.
- row_addr changes after acceptance have no effect.
- Reset mid-row: all in-flight reads and FIFO contents are discarded; the module is in IDLE on the first clock edge after reset deasserts.
- Throughput: with pix_ready held high, one pixel per cycle sustained for the whole row.

Optional Feature:
- Macro: ROW_FETCH_TEST_PATTERN_EN.
- Defined:
  - Adds input test_pat (1 bit).
  - When test_pat=1 at request acceptance, no memory reads are issued for that row.
  - The FIFO is filled with generated pixels {row[7:0], col[7:0], row[7:0]^col[7:0]}, zero-extended or truncated to PIX_W.
  - Same flags, same issue/flow-control rule, same latency.
- Not defined:
  - test_pat port absent.
  - Data always comes from memory.

Test Plan:
- COLS=8, pix_ready=1, row_req with row_addr=0 -> mem_addr 0..7 on consecutive cycles; 8 pixels out back-to-back; pix_sof=pix_sol=1 on pixel 0; pix_eol=1 on pixel 7; row_busy falls after the last handshake.
- COLS=8, row_addr=5 -> mem_addr 40..47; pix_sof=0 throughout; pix_sol on pixel 0 only.
- row_req with row_addr=720 -> row_err pulse of exactly 1 cycle; no mem_rd_en; row_busy stays 0.
- pix_ready toggled 1-0-0-1 randomly -> no reads issued while fifo_count+inflight=4; no pixel lost or duplicated; data/flags stable while stalled.
- Assert reset during pixel 3 of a row -> all outputs return to reset values immediately; a new request for row 1 afterwards produces a clean 8-pixel row.
- With ROW_FETCH_TEST_PATTERN_EN, test_pat=1, row 2 -> mem_rd_en never asserted; pixel 3 = {8'd2, 8'd3, 8'd1}.
